// File: rtl/ad9517_spi_pkg.sv
// ============================================================================
// Module : ad9517_spi_pkg
// Brief  : Shared state encoding, instruction-word field positions and helpers
//          for the AD9517 single-byte SPI engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ad9517_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam int RW_BIT     = 23;
  localparam int W_MSB      = 22;
  localparam int W_LSB      = 21;
  localparam int ADDR_MSB   = 20;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;
  localparam int INSTR_BITS = 16;
  localparam int TOTAL_BITS = 24;

  // Read instruction: R/W forced high, data phase driven as zeros.
  function automatic logic [TOTAL_BITS-1:0] read_word(
    input logic [W_MSB:W_LSB]       w_field,
    input logic [ADDR_MSB:ADDR_LSB] addr
  );
    logic [TOTAL_BITS-1:0] r;
    r                    = '0;
    r[RW_BIT]            = 1'b1;
    r[W_MSB:W_LSB]       = w_field;
    r[ADDR_MSB:ADDR_LSB] = addr;
    r[DATA_MSB:0]        = '0;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad9517_spi_clkgen.sv
// ============================================================================
// Module : ad9517_spi_clkgen
// Brief  : SCLK divider (CPOL=0) with 1-cycle strobes marking the clk edge on
//          which SCLK rises or falls; held low and reset while disabled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ad9517_spi_clkgen
  import ad9517_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             half_done;

  assign half_done = i_en && (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d  = '0;
    sclk_d = 1'b0;
    if (i_en) begin
      div_d  = half_done ? '0 : div_q + DIV_W'(1);
      sclk_d = half_done ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign o_sclk = sclk_q;
  assign o_rise = half_done && !sclk_q;
  assign o_fall = half_done && sclk_q;

endmodule

`default_nettype wire

// File: rtl/ad9517_spi_if.sv
// ============================================================================
// Module : ad9517_spi_if
// Brief  : Single-byte 3-wire SPI engine for the AD9517. Define AD9517_4WIRE_EN
//          to sample read data from i_sdo and keep SDIO driven for all bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ad9517_spi_if
  import ad9517_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_spi_wr_cmd,
  input  logic        i_spi_rd_cmd,
  input  logic [23:0] i_spi_wr_data,
  output logic        o_spi_busy,
  output logic [7:0]  o_spi_rd_data,
  output logic        o_spi_rd_valid,
  output logic        o_sclk,
  output logic        o_cs_n,
  output logic        o_sdio_out,
  output logic        o_sdio_oe,
  input  logic        i_sdio_in,
  input  logic        i_sdo
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                           ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [4:0] DATA_START = 5'(TOTAL_BITS - INSTR_BITS);

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [TOTAL_BITS-1:0] sr_q, sr_d;
  logic [7:0]            rd_sr_q, rd_sr_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  is_rd_q, is_rd_d;
  logic                  busy_q, busy_d;
  logic                  cs_n_q, cs_n_d;
  logic                  oe_q, oe_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  sclk, sclk_rise, sclk_fall;
  logic                  sample_bit;

`ifdef AD9517_4WIRE_EN
  logic unused_sdio_in;
  assign sample_bit     = i_sdo;
  assign unused_sdio_in = i_sdio_in;
`else
  logic unused_sdo;
  assign sample_bit = i_sdio_in;
  assign unused_sdo = i_sdo;
`endif

  ad9517_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .nrst   (nrst),
    .i_en   (state_q == SHIFT),
    .o_sclk (sclk),
    .o_rise (sclk_rise),
    .o_fall (sclk_fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    rd_sr_d    = rd_sr_q;
    rd_data_d  = rd_data_q;
    is_rd_d    = is_rd_q;
    busy_d     = busy_q;
    cs_n_d     = cs_n_q;
    oe_d       = oe_q;
    rd_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Write has priority when both strobes arrive together.
        if (i_spi_wr_cmd || i_spi_rd_cmd) begin
          is_rd_d   = !i_spi_wr_cmd;
          sr_d      = i_spi_wr_cmd ? i_spi_wr_data
                    : read_word(i_spi_wr_data[W_MSB:W_LSB], i_spi_wr_data[ADDR_MSB:ADDR_LSB]);
          rd_sr_d   = '0;
          bit_cnt_d = 5'(TOTAL_BITS - 1);
          cnt_d     = '0;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          oe_d      = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (sclk_rise && is_rd_q && (bit_cnt_q < DATA_START)) begin
          rd_sr_d = {rd_sr_q[6:0], sample_bit};
        end
        if (sclk_fall) begin
          sr_d      = {sr_q[TOTAL_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 5'd1;
`ifndef AD9517_4WIRE_EN
          // Turn the pad around once the instruction phase is fully clocked.
          if (is_rd_q && (bit_cnt_q == DATA_START)) begin
            oe_d = 1'b0;
          end
`endif
          if (bit_cnt_q == 5'd0) begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Publish read data so the pulse lands in the final HOLD cycle.
    if (is_rd_q && (state_d == HOLD) && (cnt_d == CNT_W'(CS_HOLD - 1))) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_sr_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      rd_sr_q    <= '0;
      rd_data_q  <= '0;
      is_rd_q    <= 1'b0;
      busy_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      rd_sr_q    <= rd_sr_d;
      rd_data_q  <= rd_data_d;
      is_rd_q    <= is_rd_d;
      busy_q     <= busy_d;
      cs_n_q     <= cs_n_d;
      oe_q       <= oe_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_spi_busy     = busy_q;
  assign o_spi_rd_data  = rd_data_q;
  assign o_spi_rd_valid = rd_valid_q;
  assign o_sclk         = sclk;
  assign o_cs_n         = cs_n_q;
  assign o_sdio_out     = sr_q[TOTAL_BITS-1];
  assign o_sdio_oe      = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ad9517_spi_if.sv
// ============================================================================
// Module : tb_ad9517_spi_if
// Brief  : Self-checking bench: vector table, random transactions against a
//          behavioural model, busy-window command injection and mid-shift reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ad9517_spi_if;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 4;
  localparam int BUSY_LEN = CS_SETUP + 48 * CLK_DIV + CS_HOLD + CS_IDLE;
  localparam int CS_LEN   = BUSY_LEN - CS_IDLE;
`ifdef AD9517_4WIRE_EN
  localparam bit FOUR_WIRE = 1'b1;
`else
  localparam bit FOUR_WIRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_spi_wr_cmd, i_spi_rd_cmd;
  logic [23:0] i_spi_wr_data;
  logic        o_spi_busy;
  logic [7:0]  o_spi_rd_data;
  logic        o_spi_rd_valid;
  logic        o_sclk, o_cs_n, o_sdio_out, o_sdio_oe;
  logic        i_sdio_in, i_sdo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ad9517_spi_if #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .CS_IDLE  (CS_IDLE)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .i_spi_wr_cmd   (i_spi_wr_cmd),
    .i_spi_rd_cmd   (i_spi_rd_cmd),
    .i_spi_wr_data  (i_spi_wr_data),
    .o_spi_busy     (o_spi_busy),
    .o_spi_rd_data  (o_spi_rd_data),
    .o_spi_rd_valid (o_spi_rd_valid),
    .o_sclk         (o_sclk),
    .o_cs_n         (o_cs_n),
    .o_sdio_out     (o_sdio_out),
    .o_sdio_oe      (o_sdio_oe),
    .i_sdio_in      (i_sdio_in),
    .i_sdo          (i_sdo)
  );

  typedef struct {
    int          busy_cyc;
    int          cs_cyc;
    int          valid_cnt;
    int          rises;
    int          per_err;
    int          sclk_cs_err;
    logic [23:0] mosi;
    logic [23:0] oe_mask;
    logic [7:0]  rd_data;
    bit          timeout;
    bit          aborted;
  } res_t;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [23:0] data;
    logic [7:0]  slave;
    logic [23:0] exp_mosi;
    bit          exp_valid;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t        vecs[6];
  res_t        r;
  logic [7:0]  model_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: what goes out on MOSI is the command word, with reads re-coded as
  // R/W=1 plus the W/addr fields and an all-zero data phase.
  function automatic logic [23:0] model_word(input bit wr, input logic [23:0] d);
    return wr ? d : ((d & 24'h7FFF00) | 24'h800000);
  endfunction

  function automatic logic [23:0] model_oe(input bit is_read);
    return (is_read && !FOUR_WIRE) ? 24'hFFFF00 : 24'hFFFFFF;
  endfunction

  // Issue one command at the current negedge and observe the whole busy window.
  task automatic do_txn(input bit wr, input bit rd, input logic [23:0] data,
                        input logic [7:0] slave, input int inj_a, input int inj_b,
                        input int abort_rise, output res_t o);
    bit prev_sclk = 1'b0;
    bit done      = 1'b0;
    int falls     = 0;
    int last_rise = 0;
    o.busy_cyc = 0; o.cs_cyc = 0; o.valid_cnt = 0; o.rises = 0;
    o.per_err = 0; o.sclk_cs_err = 0; o.mosi = '0; o.oe_mask = '0;
    o.rd_data = '0; o.timeout = 1'b0; o.aborted = 1'b0;
    i_sdio_in = FOUR_WIRE; i_sdo = 1'b0;
    i_spi_wr_cmd = wr; i_spi_rd_cmd = rd; i_spi_wr_data = data;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      i_spi_rd_cmd = 1'b0;
      if (!o_spi_busy) begin
        done = 1'b1;
        i_spi_wr_cmd = 1'b0;
      end else begin
        o.busy_cyc++;
        if (o.busy_cyc == inj_a || o.busy_cyc == inj_b) begin
          i_spi_wr_cmd = 1'b1; i_spi_wr_data = 24'hFFFFFF;
        end else begin
          i_spi_wr_cmd = 1'b0;
        end
        if (!o_cs_n) o.cs_cyc++;
        if (o_sclk && o_cs_n) o.sclk_cs_err++;
        if (o_spi_rd_valid) begin
          o.valid_cnt++;
          o.rd_data = o_spi_rd_data;
        end
        if (o_sclk && !prev_sclk) begin
          o.rises++;
          o.mosi    = {o.mosi[22:0], o_sdio_out};
          o.oe_mask = {o.oe_mask[22:0], o_sdio_oe};
          if (o.rises > 1 && (c - last_rise) != 2 * CLK_DIV) o.per_err++;
          last_rise = c;
          if (abort_rise != 0 && o.rises == abort_rise) begin
            nrst = 1'b0;
            #1;
            check("abort_cs_n",  o_cs_n, 1);
            check("abort_sclk",  o_sclk, 0);
            check("abort_oe",    o_sdio_oe, 0);
            check("abort_busy",  o_spi_busy, 0);
            check("abort_sdio",  o_sdio_out, 0);
            check("abort_rdata", o_spi_rd_data, 0);
            o.aborted = 1'b1;
            done = 1'b1;
          end
        end
        if (!o_sclk && prev_sclk) begin
          falls++;
          if (falls >= 16 && falls <= 23) begin
            if (FOUR_WIRE) begin
              i_sdo = slave[23 - falls]; i_sdio_in = 1'b1;
            end else begin
              i_sdio_in = slave[23 - falls]; i_sdo = ~slave[23 - falls];
            end
          end
        end
        prev_sclk = o_sclk;
      end
    end
    if (!done) o.timeout = 1'b1;
    i_spi_wr_cmd = 1'b0;
  endtask

  task automatic check_txn(input string nm, input res_t t, input logic [23:0] exp_mosi,
                           input bit is_read, input logic [7:0] exp_rd);
    check({nm, ".timeout"}, t.timeout, 0);
    check({nm, ".busy_len"}, t.busy_cyc, BUSY_LEN);
    check({nm, ".cs_len"}, t.cs_cyc, CS_LEN);
    check({nm, ".rises"}, t.rises, 24);
    check({nm, ".mosi"}, t.mosi, exp_mosi);
    check({nm, ".oe"}, t.oe_mask, model_oe(is_read));
    check({nm, ".period"}, t.per_err, 0);
    check({nm, ".sclk_cs"}, t.sclk_cs_err, 0);
    check({nm, ".valid_cnt"}, t.valid_cnt, is_read ? 1 : 0);
    if (is_read) check({nm, ".valid_data"}, t.rd_data, exp_rd);
    check({nm, ".rd_held"}, o_spi_rd_data, exp_rd);
  endtask

  initial begin
    nrst = 1'b0;
    i_spi_wr_cmd = 1'b0; i_spi_rd_cmd = 1'b0; i_spi_wr_data = '0;
    i_sdio_in = 1'b0; i_sdo = 1'b0;
    model_rd = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_busy", o_spi_busy, 0);
    check("rst_rdata", o_spi_rd_data, 0);
    check("rst_valid", o_spi_rd_valid, 0);
    check("rst_sclk", o_sclk, 0);
    check("rst_cs_n", o_cs_n, 1);
    check("rst_sdio", o_sdio_out, 0);
    check("rst_oe", o_sdio_oe, 0);
    nrst = 1'b1;
    @(negedge clk);

    //         wr    rd    data        slave  exp_mosi    valid exp_rd
    vecs[0] = '{1'b1, 1'b0, 24'h00107C, 8'h00, 24'h00107C, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 24'h001000, 8'hA5, 24'h801000, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 24'h00235A, 8'h77, 24'h00235A, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 24'h7FFFFF, 8'h3C, 24'hFFFF00, 1'b1, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 24'h0AB0CD, 8'h81, 24'h8AB000, 1'b1, 8'h81};
    vecs[5] = '{1'b1, 1'b0, 24'h8000FF, 8'hFF, 24'h8000FF, 1'b0, 8'h81};
    foreach (vecs[i]) begin
      do_txn(vecs[i].wr, vecs[i].rd, vecs[i].data, vecs[i].slave, 0, 0, 0, r);
      check_txn($sformatf("vec%0d", i), r, vecs[i].exp_mosi, vecs[i].exp_valid,
                vecs[i].exp_rd);
    end
    model_rd = 8'h81;

    for (int n = 0; n < 8; n++) begin
      bit          wr, rd;
      logic [23:0] d;
      logic [7:0]  s;
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!wr && !rd) rd = 1'b1;
      d = 24'($urandom);
      s = 8'($urandom);
      if (!wr) model_rd = s;
      do_txn(wr, rd, d, s, 0, 0, 0, r);
      check_txn($sformatf("rnd%0d", n), r, model_word(wr, d), !wr, model_rd);
    end

    // Commands inside the busy window are dropped; the first idle cycle accepts.
    do_txn(1'b1, 1'b0, 24'h012345, 8'h00, 50, 199, 0, r);
    check_txn("inject", r, 24'h012345, 1'b0, model_rd);
    do_txn(1'b1, 1'b0, 24'h0ABCDE, 8'h00, 0, 0, 0, r);
    check_txn("after_inject", r, 24'h0ABCDE, 1'b0, model_rd);

    // Reset while bit 10 is on the wire (rise 14), during a read.
    do_txn(1'b0, 1'b1, 24'h001000, 8'h5A, 0, 0, 14, r);
    check("abort_taken", r.aborted, 1);
    check("abort_no_valid", r.valid_cnt, 0);
    model_rd = 8'h00;
    begin
      int bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (o_spi_busy || o_spi_rd_valid || !o_cs_n || o_sclk) bad++;
      end
      check("abort_quiet", bad, 0);
    end
    nrst = 1'b1;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 24'h00107C, 8'h00, 0, 0, 0, r);
    check_txn("post_abort_wr", r, 24'h00107C, 1'b0, model_rd);
    model_rd = 8'h96;
    do_txn(1'b0, 1'b1, 24'h601200, 8'h96, 0, 0, 0, r);
    check_txn("post_abort_rd", r, 24'hE01200, 1'b1, model_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
